// File: rtl/ring_msg_port.sv
// Slotted-ring message port: token-based transmit, header+payload receive into a
// first-word-fall-through queue, and a CPU read-out sequencer.
//
// state      | meaning
// IDLE       | no transfer; answers empty-queue reads directly
// WAIT_TOKEN | send pending, watching for the token slot
// WAIT_TRAIN | token claimed, letting the existing train pass
// SEND_HDR   | driving our header slot
// SEND_PAY   | driving payload slots, one per word
// COPY_HDR   | popping a queued header to the CPU
// COPY_PAY   | popping queued payload words to the CPU
module ring_msg_port #(
    parameter int CW    = 4,
    parameter int TW    = 4,
    parameter int LW    = 6,
    parameter int DEPTH = 64,
    parameter bit BCAST = 1'b1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CW-1:0]             whichCore,
    input  logic                      txReq,
    input  logic [CW-1:0]             txDest,
    input  logic [TW-1:0]             txType,
    input  logic [LW-1:0]             txLen,
    input  logic [31:0]               txData,
    output logic                      txPop,
    output logic                      txDone,
    input  logic                      rxReq,
    output logic [31:0]               rxData,
    output logic                      rxWr,
    output logic                      rxDone,
    input  logic [31:0]               ringIn,
    input  logic [3:0]                slotTypeIn,
    input  logic [3:0]                srcDestIn,
    output logic [31:0]               ringOut,
    output logic [3:0]                slotTypeOut,
    output logic [3:0]                srcDestOut,
    output logic                      driveRing,
    output logic                      waiting,
    output logic                      ctrlValid,
    output logic [TW-1:0]             ctrlType,
    output logic [CW-1:0]             ctrlSrc,
    output logic [$clog2(DEPTH):0]    mqCount,
    output logic [15:0]               dropCount
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [3:0] SLOT_TOKEN = 4'd1;
    localparam logic [3:0] SLOT_NULL  = 4'd7;
    localparam logic [3:0] SLOT_MSG   = 4'd8;
    localparam logic [3:0] SLOT_BCST  = 4'd12;

    typedef enum logic [2:0] {
        IDLE, WAIT_TOKEN, WAIT_TRAIN, SEND_HDR, SEND_PAY, COPY_HDR, COPY_PAY
    } state_t;

    state_t          r_state, w_next;
    logic [7:0]      r_train;
    logic [LW-1:0]   r_tx_cnt, r_cp_cnt, r_rx_cnt;
    logic            r_accept;
    logic [31:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [AW:0]     r_count;
    logic [15:0]     r_drop;

    logic [3:0]      w_core4, w_dest4, w_tx_slot;
    logic [31:0]     w_hdr, w_q_head;
    logic [LW-1:0]   w_rx_len;
    logic [AW:0]     w_free, w_need;
    logic            w_token, w_to_me, w_bc_other, w_bc_own, w_first, w_fits;
    logic            w_q_wr, w_q_rd, w_drop;

    assign w_core4   = 4'(whichCore);
    assign w_dest4   = 4'(txDest);
    assign w_tx_slot = (BCAST && txDest == whichCore) ? SLOT_BCST : SLOT_MSG;
    assign w_hdr     = 32'({whichCore, txType, txLen});
    assign w_token   = (slotTypeIn == SLOT_TOKEN);
    assign w_q_head  = r_mem[r_rd_ptr];

    // Receive side runs regardless of the transmit/copy state.
    assign w_to_me    = (slotTypeIn == SLOT_MSG) && (srcDestIn == w_core4);
    assign w_bc_other = BCAST && (slotTypeIn == SLOT_BCST) && (srcDestIn != w_core4);
    assign w_bc_own   = BCAST && (slotTypeIn == SLOT_BCST) && (srcDestIn == w_core4);
    assign w_first    = (r_rx_cnt == '0) && (w_to_me || w_bc_other);
    assign w_rx_len   = ringIn[LW-1:0];
    assign w_free     = DEPTH_W - r_count;
    assign w_need     = (AW+1)'(w_rx_len) + (AW+1)'(1);
    assign w_fits     = (w_free >= w_need);
    assign w_drop     = w_first && (w_rx_len != '0) && !w_fits;
    assign w_q_wr     = (w_first && (w_rx_len != '0) && w_fits) || ((r_rx_cnt != '0) && r_accept);

    assign ctrlValid  = !reset && w_first && (w_rx_len == '0);
    assign ctrlType   = ringIn[LW+TW-1:LW];
    assign ctrlSrc    = ringIn[LW+TW+CW-1:LW+TW];
    assign mqCount    = r_count;
    assign dropCount  = r_drop;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_cnt <= '0;
            r_accept <= 1'b0;
            r_drop   <= '0;
        end else begin
            if (w_first) begin
                r_rx_cnt <= w_rx_len;
                r_accept <= w_fits;
            end else if (r_rx_cnt != '0) begin
                r_rx_cnt <= r_rx_cnt - 1'b1;
            end
            if (w_drop && r_drop != 16'hFFFF)
                r_drop <= r_drop + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_q_wr)
            r_mem[r_wr_ptr] <= ringIn;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_q_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_q_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_q_wr, w_q_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_train  <= '0;
            r_tx_cnt <= '0;
            r_cp_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == WAIT_TOKEN && w_token) r_train  <= ringIn[7:0];
            if (r_state == WAIT_TRAIN)            r_train  <= r_train - 1'b1;
            if (r_state == SEND_HDR)              r_tx_cnt <= txLen;
            if (r_state == SEND_PAY)              r_tx_cnt <= r_tx_cnt - 1'b1;
            if (r_state == COPY_HDR)              r_cp_cnt <= w_q_head[LW-1:0];
            if (r_state == COPY_PAY)              r_cp_cnt <= r_cp_cnt - 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:       if (txReq) w_next = WAIT_TOKEN;
                        else if (rxReq && r_count != '0) w_next = COPY_HDR;
            WAIT_TOKEN: if (w_token) w_next = (ringIn[7:0] == 8'd0) ? SEND_HDR : WAIT_TRAIN;
            WAIT_TRAIN: if (r_train <= 8'd1) w_next = SEND_HDR;
            SEND_HDR:   w_next = (txLen == '0) ? IDLE : SEND_PAY;
            SEND_PAY:   if (r_tx_cnt == LW'(1)) w_next = IDLE;
            COPY_HDR:   w_next = (w_q_head[LW-1:0] == '0) ? IDLE : COPY_PAY;
            COPY_PAY:   if (r_cp_cnt == LW'(1)) w_next = IDLE;
            default:    w_next = IDLE;
        endcase
    end

    always_comb begin
        ringOut     = ringIn;
        slotTypeOut = slotTypeIn;
        srcDestOut  = srcDestIn;
        driveRing   = 1'b0;
        txPop       = 1'b0;
        txDone      = 1'b0;
        rxWr        = 1'b0;
        rxDone      = 1'b0;
        rxData      = '0;
        waiting     = 1'b0;
        w_q_rd      = 1'b0;
        // Our own traffic is removed from the ring once it reaches its end point.
        if (w_to_me || w_bc_own) begin
            ringOut     = '0;
            slotTypeOut = SLOT_NULL;
            srcDestOut  = '0;
            driveRing   = 1'b1;
        end
        case (r_state)
            IDLE: begin
                if (!txReq && rxReq && r_count == '0) begin
                    rxWr   = 1'b1;
                    rxDone = 1'b1;
                end
            end
            WAIT_TOKEN: begin
                waiting = 1'b1;
                if (w_token) begin
                    ringOut     = ringIn + 32'(txLen) + 32'd1;
                    slotTypeOut = SLOT_TOKEN;
                    srcDestOut  = srcDestIn;
                    driveRing   = 1'b1;
                end
            end
            SEND_HDR: begin
                ringOut     = w_hdr;
                slotTypeOut = w_tx_slot;
                srcDestOut  = w_dest4;
                driveRing   = 1'b1;
                txDone      = (txLen == '0);
            end
            SEND_PAY: begin
                ringOut     = txData;
                slotTypeOut = w_tx_slot;
                srcDestOut  = w_dest4;
                driveRing   = 1'b1;
                txPop       = 1'b1;
                txDone      = (r_tx_cnt == LW'(1));
            end
            COPY_HDR: begin
                w_q_rd = 1'b1;
                rxWr   = 1'b1;
                rxData = w_q_head;
                rxDone = (w_q_head[LW-1:0] == '0);
            end
            COPY_PAY: begin
                w_q_rd = 1'b1;
                rxWr   = 1'b1;
                rxData = w_q_head;
                rxDone = (r_cp_cnt == LW'(1));
            end
            default: ;
        endcase
        if (reset) begin
            ringOut     = ringIn;
            slotTypeOut = slotTypeIn;
            srcDestOut  = srcDestIn;
            driveRing   = 1'b0;
            txPop       = 1'b0;
            txDone      = 1'b0;
            rxWr        = 1'b0;
            rxDone      = 1'b0;
            w_q_rd      = 1'b0;
        end
    end
endmodule

// File: tb/tb_ring_msg_port.sv
// Directed bench for ring_msg_port: transmit, train wait, control messages,
// queue fill/drop, CPU read-out, broadcast and reset behaviour.
module tb_ring_msg_port;
    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  whichCore, txDest, txType, ctrlType, ctrlSrc;
    logic [5:0]  txLen;
    logic [31:0] txData, rxData, ringIn, ringOut;
    logic        txReq, txPop, txDone, rxReq, rxWr, rxDone;
    logic [3:0]  slotTypeIn, srcDestIn, slotTypeOut, srcDestOut;
    logic        driveRing, waiting, ctrlValid;
    logic [6:0]  mqCount;
    logic [15:0] dropCount;
    int          checks = 0;
    int          errors = 0;

    ring_msg_port dut (
        .clock(clock), .reset(reset), .whichCore(whichCore),
        .txReq(txReq), .txDest(txDest), .txType(txType), .txLen(txLen), .txData(txData),
        .txPop(txPop), .txDone(txDone),
        .rxReq(rxReq), .rxData(rxData), .rxWr(rxWr), .rxDone(rxDone),
        .ringIn(ringIn), .slotTypeIn(slotTypeIn), .srcDestIn(srcDestIn),
        .ringOut(ringOut), .slotTypeOut(slotTypeOut), .srcDestOut(srcDestOut),
        .driveRing(driveRing), .waiting(waiting),
        .ctrlValid(ctrlValid), .ctrlType(ctrlType), .ctrlSrc(ctrlSrc),
        .mqCount(mqCount), .dropCount(dropCount)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ring(input logic [3:0] st, input logic [3:0] sd, input logic [31:0] d);
        slotTypeIn = st;
        srcDestIn  = sd;
        ringIn     = d;
    endtask

    initial begin
        reset = 1'b1; whichCore = 4'd2;
        txReq = 0; txDest = 0; txType = 0; txLen = 0; txData = 0; rxReq = 1'b1;
        ring(4'd8, 4'd2, 32'h0000_0E40);
        tick(); tick();
        chk("rst_rxWr", rxWr, 0);
        chk("rst_rxDone", rxDone, 0);
        chk("rst_drive", driveRing, 0);
        chk("rst_ctrl", ctrlValid, 0);
        reset = 1'b0; rxReq = 1'b0; ring(4'd7, 4'd0, 0);
        tick();
        chk("rst_mq", mqCount, 0);
        chk("rst_drop", dropCount, 0);
        chk("rst_wait", waiting, 0);

        // empty-queue read answers immediately
        rxReq = 1'b1; #1;
        chk("empty_rxData", rxData, 0);
        chk("empty_rxWr", rxWr, 1);
        chk("empty_rxDone", rxDone, 1);
        tick(); rxReq = 1'b0;

        // basic send: dest 5, type 3, three words
        txReq = 1; txDest = 4'd5; txType = 4'd3; txLen = 6'd3; txData = 32'hA0;
        tick(); #1;
        chk("tx_waiting", waiting, 1);
        chk("tx_wait_nodrive", driveRing, 0);
        ring(4'd1, 4'd0, 0); #1;
        chk("tok_ringOut", ringOut, 4);
        chk("tok_drive", driveRing, 1);
        chk("tok_slot", slotTypeOut, 1);
        tick(); ring(4'd7, 4'd0, 0); #1;
        chk("hdr_word", ringOut, 32'h8C3);
        chk("hdr_slot", slotTypeOut, 8);
        chk("hdr_dest", srcDestOut, 5);
        chk("hdr_drive", driveRing, 1);
        chk("hdr_nodone", txDone, 0);
        for (int w = 0; w < 3; w++) begin
            tick(); txData = 32'hA0 + w; #1;
            chk("pay_word", ringOut, 32'hA0 + w);
            chk("pay_pop", txPop, 1);
            chk("pay_slot", slotTypeOut, 8);
            chk("pay_done", txDone, (w == 2) ? 1 : 0);
        end
        tick(); txReq = 0; #1;
        chk("tx_end_pop", txPop, 0);
        chk("tx_end_idle", waiting, 0);

        // token with a 2-slot train already in flight
        txReq = 1; txLen = 0; txType = 4'd1; txDest = 4'd5;
        tick(); ring(4'd1, 4'd0, 32'd2); #1;
        chk("train_tok", ringOut, 3);
        tick(); ring(4'd7, 4'd0, 0); #1;
        chk("train_c1", driveRing, 0);
        tick();
        chk("train_c2", driveRing, 0);
        tick();
        chk("train_hdr_drive", driveRing, 1);
        chk("train_hdr", ringOut, 32'h840);
        chk("train_done", txDone, 1);
        tick(); txReq = 0;

        // zero-length control message to us
        ring(4'd8, 4'd2, 32'hE40); #1;
        chk("ctrl_valid", ctrlValid, 1);
        chk("ctrl_type", ctrlType, 9);
        chk("ctrl_src", ctrlSrc, 3);
        chk("ctrl_null", slotTypeOut, 7);
        chk("ctrl_drive", driveRing, 1);
        tick(); ring(4'd7, 4'd0, 0); #1;
        chk("ctrl_mq", mqCount, 0);
        chk("ctrl_clear", ctrlValid, 0);

        // foreign message passes through untouched
        ring(4'd8, 4'd6, 32'h1234); #1;
        chk("pass_drive", driveRing, 0);
        chk("pass_data", ringOut, 32'h1234);
        chk("pass_dest", srcDestOut, 6);
        tick();

        // store a 2-payload message and read it back
        ring(4'd8, 4'd2, 32'hD42); tick();
        ring(4'd8, 4'd2, 32'h11); #1;
        chk("rxpay_null", slotTypeOut, 7);
        tick();
        ring(4'd8, 4'd2, 32'h22); tick();
        ring(4'd7, 4'd0, 0); #1;
        chk("store_mq", mqCount, 3);
        rxReq = 1; #1;
        chk("rd_idle", rxWr, 0);
        tick();
        chk("rd_hdr", rxData, 32'hD42);
        chk("rd_hdr_wr", rxWr, 1);
        tick();
        chk("rd_p0", rxData, 32'h11);
        chk("rd_p0_done", rxDone, 0);
        tick();
        chk("rd_p1", rxData, 32'h22);
        chk("rd_p1_wr", rxWr, 1);
        chk("rd_p1_done", rxDone, 1);
        rxReq = 0;
        tick();
        chk("rd_mq", mqCount, 0);
        chk("rd_end", rxWr, 0);

        // fill to 60 words, then a drop and a fitting message
        for (int m = 0; m < 15; m++) begin
            ring(4'd8, 4'd2, 32'h403); tick();
            for (int w = 0; w < 3; w++) begin
                ring(4'd8, 4'd2, m * 16 + w); tick();
            end
        end
        ring(4'd7, 4'd0, 0); #1;
        chk("fill_mq", mqCount, 60);
        ring(4'd8, 4'd2, 32'h404); tick();
        for (int w = 0; w < 4; w++) begin
            ring(4'd8, 4'd2, 32'hF0 + w); tick();
        end
        ring(4'd7, 4'd0, 0); #1;
        chk("drop_cnt", dropCount, 1);
        chk("drop_mq", mqCount, 60);
        ring(4'd8, 4'd2, 32'h403); tick();
        for (int w = 0; w < 3; w++) begin
            ring(4'd8, 4'd2, 32'hE0 + w); tick();
        end
        ring(4'd7, 4'd0, 0); #1;
        chk("full_mq", mqCount, 64);
        chk("full_drop", dropCount, 1);

        // read while a new message arrives
        rxReq = 1; tick();
        chk("rw_hdr", rxData, 32'h403);
        tick();
        chk("rw_p0", rxData, 0);
        tick();
        ring(4'd8, 4'd2, 32'h401); #1;
        chk("rw_p1", rxData, 1);
        tick();
        ring(4'd8, 4'd2, 32'h55); #1;
        chk("rw_p2", rxData, 2);
        chk("rw_done", rxDone, 1);
        chk("rw_mq_hold", mqCount, 62);
        rxReq = 0;
        tick();
        ring(4'd7, 4'd0, 0); #1;
        chk("rw_mq", mqCount, 62);

        // broadcast from core 2
        txReq = 1; txDest = 4'd2; txLen = 6'd1; txType = 4'd4; txData = 32'hBB;
        tick(); ring(4'd1, 4'd0, 0); #1;
        chk("bc_tok", ringOut, 2);
        tick(); ring(4'd7, 4'd0, 0); #1;
        chk("bc_slot", slotTypeOut, 12);
        chk("bc_dest", srcDestOut, 2);
        chk("bc_hdr", ringOut, 32'h901);
        tick();
        chk("bc_pay", ringOut, 32'hBB);
        chk("bc_done", txDone, 1);
        tick(); txReq = 0;
        whichCore = 4'd4;
        ring(4'd12, 4'd2, 32'h901); #1;
        chk("bc4_pass", driveRing, 0);
        chk("bc4_slot", slotTypeOut, 12);
        tick();
        ring(4'd12, 4'd2, 32'hBB); tick();
        ring(4'd7, 4'd0, 0); whichCore = 4'd2; #1;
        chk("bc4_mq", mqCount, 64);
        ring(4'd12, 4'd2, 32'h901); #1;
        chk("bc_ret_null", slotTypeOut, 7);
        chk("bc_ret_drive", driveRing, 1);
        tick();
        ring(4'd12, 4'd2, 32'hBB); #1;
        chk("bc_ret_pay_null", slotTypeOut, 7);
        tick();
        ring(4'd7, 4'd0, 0); #1;
        chk("bc_ret_mq", mqCount, 64);

        // reset in the middle of a send
        txReq = 1; txDest = 4'd5; txLen = 6'd2; txType = 4'd0;
        tick(); ring(4'd1, 4'd0, 0);
        tick(); ring(4'd7, 4'd0, 0);
        tick();
        chk("pre_rst_pop", txPop, 1);
        reset = 1; #1;
        chk("midrst_pop", txPop, 0);
        chk("midrst_done", txDone, 0);
        chk("midrst_drive", driveRing, 0);
        tick(); reset = 0; txReq = 0;
        tick();
        chk("post_rst_wait", waiting, 0);
        chk("post_rst_mq", mqCount, 0);
        chk("post_rst_drop", dropCount, 0);
        chk("post_rst_pop", txPop, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
